// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - ordered reset release (APB, UART, core) gated by stable PLL lock
module rst_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int STAGE_DELAY        = 16,
  parameter int SW_RST_CYCLES      = 32
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pll_locked_i,
  input  logic       sw_reset_req_i,
  output logic       apb_resetn_o,
  output logic       uart_resetn_o,
  output logic       core_resetn_o,
  output logic       seq_done_o,
  output logic [2:0] state_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int MAX_AB = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int MAX_ALL = (MAX_AB > SW_RST_CYCLES) ? MAX_AB : SW_RST_CYCLES;
  localparam int CNT_W = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] SW_LAST    = CNT_W'(SW_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    REL_APB   = 3'd2,
    REL_UART  = 3'd3,
    RUN       = 3'd4,
    SW_RST    = 3'd5
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             sync1_q, sync2_q;
  logic             locked_s;
  logic             watched;
  logic             lock_loss;
  logic             apb_n, uart_n, core_n, done_n;

  // pll_locked_i is asynchronous; only sync1_q ever samples it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked_i;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;
  assign watched  = (state_q == STABLE) || (state_q == REL_APB) || (state_q == REL_UART) ||
                    (state_q == RUN) || (state_q == SW_RST);

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    lock_loss = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (locked_s) state_n = STABLE;
      end
      STABLE: begin
        if (cnt_q == LOCK_LAST) begin
          state_n = REL_APB;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      REL_APB: begin
        if (cnt_q == STAGE_LAST) begin
          state_n = REL_UART;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      REL_UART: begin
        if (cnt_q == STAGE_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_n = '0;
        if (sw_reset_req_i) state_n = SW_RST;
      end
      SW_RST: begin
        // Warm reset goes straight back to staged release, lock is already proven.
        if (cnt_q == SW_LAST) begin
          state_n = REL_APB;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
    endcase
    // Lock loss overrides warm-reset requests and counter expiry.
    if (watched && !locked_s) begin
      state_n   = WAIT_LOCK;
      cnt_n     = '0;
      lock_loss = 1'b1;
    end
  end

  always_comb begin
    apb_n  = (state_n == REL_APB) || (state_n == REL_UART) || (state_n == RUN);
    uart_n = (state_n == REL_UART) || (state_n == RUN);
    core_n = (state_n == RUN);
    done_n = (state_n == RUN);
  end

  // Outputs are decoded from the next state so they switch on the same edge as state_q.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      apb_resetn_o    <= 1'b0;
      uart_resetn_o   <= 1'b0;
      core_resetn_o   <= 1'b0;
      seq_done_o      <= 1'b0;
      lock_loss_cnt_o <= 8'd0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      apb_resetn_o  <= apb_n;
      uart_resetn_o <= uart_n;
      core_resetn_o <= core_n;
      seq_done_o    <= done_n;
      if (lock_loss && (lock_loss_cnt_o != 8'hFF)) begin
        lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
      end
    end
  end

  assign state_o = state_q;

endmodule
